// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary ROWS x COLS signed systolic matrix multiplier with skewed
// operand injection, optional accumulate mode and a row-serial drain with backpressure.
module systolic_mm_engine #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 2*DATAWIDTH+4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic                                in_accum,
  input  logic [ROWS-1:0][DATAWIDTH-1:0]      a_in,
  input  logic [COLS-1:0][DATAWIDTH-1:0]      b_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(ROWS)-1:0]             out_row,
  output logic                                out_last,
  output logic [COLS-1:0][ACCWIDTH-1:0]       c_out,
  output logic                                busy
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS+COLS);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic beat, adv, clr, load_ph;
  logic signed [DATAWIDTH-1:0] a_inj [ROWS];
  logic signed [DATAWIDTH-1:0] b_inj [COLS];
  logic signed [DATAWIDTH-1:0] a_h [ROWS][COLS];
  logic signed [DATAWIDTH-1:0] b_v [ROWS][COLS];
  logic signed [ACCWIDTH-1:0]  acc_w [ROWS][COLS];
  assign load_ph   = state_q == IDLE || state_q == LOAD;
  assign in_ready  = !rst && load_ph;
  assign beat      = in_valid && in_ready;
  assign adv       = beat || state_q == FLUSH;
  assign clr       = beat && state_q == IDLE && !in_accum;
  assign out_valid = state_q == DRAIN;
  assign out_row   = row_q;
  assign out_last  = out_valid && row_q == RW'(ROWS-1);
  assign busy      = state_q != IDLE;
  always_comb begin
    for (int r = 0; r < ROWS; r++) a_inj[r] = load_ph ? a_in[r] : '0;
    for (int c = 0; c < COLS; c++) b_inj[c] = load_ph ? b_in[c] : '0;
    for (int c = 0; c < COLS; c++) c_out[c] = out_valid ? acc_w[row_q][c] : '0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      IDLE, LOAD: if (beat) begin
        state_d = in_last ? FLUSH : LOAD;
        cnt_d   = CW'(ROWS+COLS-2);
      end
      FLUSH: begin
        state_d = cnt_q == '0 ? DRAIN : FLUSH;
        cnt_d   = cnt_q - 1'b1;
      end
      default: if (out_ready) begin
        state_d = row_q == RW'(ROWS-1) ? IDLE : DRAIN;
        row_d   = row_q == RW'(ROWS-1) ? '0 : row_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  // Row i of A and column j of B enter the array i (resp. j) advancing steps late.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    if (i == 0) begin : g_d0
      assign a_h[0][0] = a_inj[0];
    end else begin : g_dn
      logic signed [DATAWIDTH-1:0] sr_q [i];
      always_ff @(posedge clk)
        if (rst) for (int s = 0; s < i; s++) sr_q[s] <= '0;
        else if (adv) begin
          sr_q[0] <= a_inj[i];
          for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
        end
      assign a_h[i][0] = sr_q[i-1];
    end
  end
  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    if (j == 0) begin : g_d0
      assign b_v[0][0] = b_inj[0];
    end else begin : g_dn
      logic signed [DATAWIDTH-1:0] sr_q [j];
      always_ff @(posedge clk)
        if (rst) for (int s = 0; s < j; s++) sr_q[s] <= '0;
        else if (adv) begin
          sr_q[0] <= b_inj[j];
          for (int s = 1; s < j; s++) sr_q[s] <= sr_q[s-1];
        end
      assign b_v[0][j] = sr_q[j-1];
    end
  end
  for (genvar i = 0; i < ROWS; i++) begin : g_r
    for (genvar j = 0; j < COLS; j++) begin : g_c
      logic signed [ACCWIDTH-1:0]    acc_q;
      logic signed [2*DATAWIDTH-1:0] prod;
      assign prod = a_h[i][j] * b_v[i][j];
      always_ff @(posedge clk)
        if (rst) acc_q <= '0;
        else if (adv) acc_q <= (clr ? '0 : acc_q) + {{(ACCWIDTH-2*DATAWIDTH){prod[2*DATAWIDTH-1]}}, prod};
      assign acc_w[i][j] = acc_q;
      if (j < COLS-1) begin : g_a
        logic signed [DATAWIDTH-1:0] a_q;
        always_ff @(posedge clk)
          if (rst) a_q <= '0;
          else if (adv) a_q <= a_h[i][j];
        assign a_h[i][j+1] = a_q;
      end
      if (i < ROWS-1) begin : g_b
        logic signed [DATAWIDTH-1:0] b_q;
        always_ff @(posedge clk)
          if (rst) b_q <= '0;
          else if (adv) b_q <= b_v[i][j];
        assign b_v[i+1][j] = b_q;
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: scoreboard bench; a matrix-level model predicts every drained row.
module tb_systolic_mm_engine;
  localparam int R = 4, C = 3, DW = 8, AW = 20;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, in_accum = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, busy;
  logic [R-1:0][DW-1:0] a_in = '0;
  logic [C-1:0][DW-1:0] b_in = '0;
  logic [1:0] out_row;
  logic [C-1:0][AW-1:0] c_out;
  int chk = 0, pass = 0;
  bit rnd_rdy = 0;
  typedef struct { int row; logic [C-1:0][AW-1:0] c; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [AW-1:0] acc_m [R][C];
  always #5 clk = ~clk;
  systolic_mm_engine #(.ROWS(R), .COLS(C), .DATAWIDTH(DW), .ACCWIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_accum(in_accum), .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_last(out_last), .c_out(c_out), .busy(busy));
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  logic stall_p = 0;
  logic [1:0] row_p;
  logic [C-1:0][AW-1:0] c_p;
  always @(negedge clk) begin
    if (rst) stall_p = 0;
    else begin
      if (stall_p) begin
        check("stall_valid", out_valid, 1);
        check("stall_row", out_row, row_p);
        check("stall_c", c_out, c_p);
      end
      if (out_valid) check("in_ready_drain", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_row", out_row, 64'hdead);
        else begin
          e = exp_q.pop_front();
          check("row_idx", out_row, e.row);
          check("row_c", c_out, e.c);
          check("row_last", out_last, e.row == R-1);
        end
      end
      stall_p = out_valid && !out_ready;
      row_p = out_row;
      c_p = c_out;
    end
  end
  initial forever begin
    @(posedge clk); #1;
    out_ready = rnd_rdy ? $urandom_range(0, 2) != 0 : 1'b1;
  end
  function automatic int opnd(int pat, int x, int y);
    case (pat)
      0: return int'($urandom_range(0, 255)) - 128;
      1: return x;
      2: return y;
      3: return -128;
      default: return 1;
    endcase
  endfunction
  task automatic run_job(int k, bit accum, int pat, int bub);
    int A[R][8];
    int B[8][C];
    int n, w;
    exp_t x;
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < R; i++) A[i][kk] = opnd(pat, int'(i == kk), 1);
      for (int j = 0; j < C; j++) B[kk][j] = opnd(pat, 4*kk+j+1, 2);
    end
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        int s = 0;
        for (int kk = 0; kk < k; kk++) s += A[i][kk] * B[kk][j];
        acc_m[i][j] = (accum ? acc_m[i][j] : '0) + AW'(s);
        x.c[j] = acc_m[i][j];
      end
      x.row = i;
      exp_q.push_back(x);
    end
    for (int kk = 0; kk < k; kk++) begin
      repeat (bub) begin
        in_valid = 0; in_last = 1; in_accum = ~accum; a_in = '1; b_in = '1;
        @(posedge clk); #1;
      end
      in_valid = 1;
      in_last = kk == k-1;
      in_accum = kk == 0 ? accum : 1'($urandom);
      for (int i = 0; i < R; i++) a_in[i] = DW'(A[i][kk]);
      for (int j = 0; j < C; j++) b_in[j] = DW'(B[kk][j]);
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    n = 1;
    while (!out_valid && n < 40) begin
      check("in_ready_flush", in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, R+C);
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_done", w < 200, 1);
  endtask
  initial begin
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) acc_m[i][j] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_last", out_last, 0);
    check("rst_c_out", c_out, 0);
    rst = 0;
    @(posedge clk); #1;
    run_job(4, 0, 1, 0);
    run_job(5, 0, 2, 0);
    run_job(5, 1, 2, 0);
    run_job(5, 0, 2, 0);
    run_job(5, 0, 2, 3);
    run_job(1, 0, 3, 0);
    rnd_rdy = 1;
    repeat (20) run_job($urandom_range(1, 8), 1'($urandom), 0, $urandom_range(0, 2));
    rnd_rdy = 0;
    repeat (2) begin
      in_valid = 1; in_last = 0; in_accum = 0; a_in = '1; b_in = '1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 0);
    rst = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) acc_m[i][j] = '0;
    repeat (12) begin
      check("midrst_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    check("midrst_busy", busy, 0);
    run_job(1, 1, 4, 0);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
